// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues one word read at a time from a running fetch PC
// and buffers returned words with their addresses until the pipeline consumes them.
module if_prefetch_queue #(
   parameter int unsigned QDEPTH   = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        use_npc,
   input  logic [31:0] npc_addr,
   input  logic        stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_data,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic        stall_req
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(QDEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

   state_e        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   old_addr_q, old_addr_d;
   logic [PW:0]   count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   pc_mem   [QDEPTH];
   logic [31:0]   inst_mem [QDEPTH];

   logic valid;
   logic push;
   logic pop;

   assign valid = (count_q != '0);
   assign pop   = valid && !stall && !use_npc;
   assign push  = (state_q == StWait) && mem_ack && !use_npc;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      old_addr_d = old_addr_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;

      unique case (state_q)
         StIdle: begin
            if (!use_npc && (count_q < CNT_FULL)) state_d = StWait;
         end
         StWait: begin
            if (mem_ack) begin
               state_d = StIdle;
            end else if (use_npc) begin
               // Keep presenting the abandoned address until memory answers it.
               state_d    = StDiscard;
               old_addr_d = fetch_pc_q;
            end
         end
         StDiscard: begin
            if (mem_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (use_npc) begin
         fetch_pc_d = npc_addr & ~32'h3;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            wr_ptr_d   = wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         old_addr_q <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else if (rdy) begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         old_addr_q <= old_addr_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Storage needs no reset: it is only observed through count.
   always_ff @(posedge clk) begin
      if (rdy && push) begin
         pc_mem[wr_ptr_q]   <= fetch_pc_q;
         inst_mem[wr_ptr_q] <= mem_data;
      end
   end

   assign mem_req    = (state_q != StIdle);
   assign mem_addr   = (state_q == StDiscard) ? old_addr_q : fetch_pc_q;
   assign inst_valid = valid;
   assign stall_req  = !valid;
   assign pc         = valid ? pc_mem[rd_ptr_q] : fetch_pc_q;
   assign inst       = valid ? inst_mem[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed scenarios plus a randomized run against a
// queue-based reference model; a second instance starts near the top of memory.
module tb_if_prefetch_queue;

   localparam int unsigned QDEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        use_npc = 1'b0;
   logic [31:0] npc_addr = 32'h0;
   logic        stall = 1'b0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_data = 32'h0;
   logic        mem_req, inst_valid, stall_req;
   logic [31:0] mem_addr, pc, inst;
   logic        w_mem_req, w_inst_valid, w_stall_req;
   logic [31:0] w_mem_addr, w_pc, w_inst;

   if_prefetch_queue #(.QDEPTH(QDEPTH), .RESET_PC(32'h0)) u_dut (
      .clk(clk), .rst(rst), .rdy(rdy), .use_npc(use_npc), .npc_addr(npc_addr),
      .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_data(mem_data), .pc(pc), .inst(inst), .inst_valid(inst_valid),
      .stall_req(stall_req)
   );

   // Same handshake timing as u_dut, so it can share the responder.
   if_prefetch_queue #(.QDEPTH(QDEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(rst), .rdy(rdy), .use_npc(use_npc), .npc_addr(npc_addr),
      .stall(stall), .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(mem_ack),
      .mem_data(mem_data), .pc(w_pc), .inst(w_inst), .inst_valid(w_inst_valid),
      .stall_req(w_stall_req)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
   ent_t        m_q[$];
   logic [31:0] m_fetch;
   logic [31:0] m_addr;
   bit          m_busy, m_drop;

   bit resp_en;
   int wait_cnt, cur_delay, max_delay;
   bit last_ack;

   task automatic model_reset();
      m_q.delete();
      m_fetch   = 32'h0;
      m_addr    = 32'h0;
      m_busy    = 0;
      m_drop    = 0;
      wait_cnt  = 0;
      cur_delay = 0;
   endtask

   // One accepted clock edge as seen from the outside: redirect wins, otherwise the
   // head may leave, a returned word may join the tail, or a new read may start.
   task automatic model_step();
      int n;
      if (!rdy) return;
      n = m_q.size();
      if (use_npc) begin
         m_q.delete();
         m_fetch = {npc_addr[31:2], 2'b00};
         if (m_busy && !mem_ack) m_drop = 1;
         else begin
            m_busy = 0;
            m_drop = 0;
         end
      end else begin
         if (n != 0 && !stall) void'(m_q.pop_front());
         if (m_busy) begin
            if (mem_ack) begin
               if (!m_drop) begin
                  m_q.push_back('{m_fetch, mem_data});
                  m_fetch = m_fetch + 32'd4;
               end
               m_busy = 0;
               m_drop = 0;
            end
         end else if (n < QDEPTH) begin
            m_busy = 1;
            m_addr = m_fetch;
         end
      end
   endtask

   // Called at posedge+1 with inputs set; memory answers, model advances, edge occurs.
   task automatic cycle();
      mem_ack = 1'b0;
      if (mem_req && rdy && rst && resp_en) begin
         if (wait_cnt >= cur_delay) begin
            mem_ack   = 1'b1;
            mem_data  = $urandom;
            wait_cnt  = 0;
            cur_delay = $urandom_range(0, max_delay);
         end else begin
            wait_cnt++;
         end
      end
      last_ack = mem_ack;
      if (rst) model_step();
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b0; rdy = 1'b1; stall = 1'b0; use_npc = 1'b0; npc_addr = 32'h0;
      resp_en = 1; max_delay = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      resp_en = 1; max_delay = 0;
      #2 rst = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
      total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL rst_stall_req: got %b want 1", stall_req); end
      total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_inst: got %h want 0", inst); end
      total++; if (w_pc !== 32'hFFFF_FFF8) begin bad++; $display("FAIL rst_w_pc: got %h want fffffff8", w_pc); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      cycle();
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
         bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
      end
      total++; if (w_mem_req !== 1'b1 || w_mem_addr !== 32'hFFFF_FFF8) begin
         bad++; $display("FAIL w_first_req: got req=%b addr=%h want 1 fffffff8", w_mem_req, w_mem_addr);
      end
   endtask

   task automatic test_streaming();
      logic [31:0] exp_pc[4]  = '{32'h0, 32'h4, 32'h8, 32'hC};
      logic [31:0] exp_wpc[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      logic [31:0] seen[$];
      logic [31:0] wseen[$];
      int          seen_cyc[$];
      apply_reset();
      for (int c = 0; c < 30 && seen.size() < 4; c++) begin
         if (inst_valid) begin
            seen.push_back(pc);
            wseen.push_back(w_pc);
            seen_cyc.push_back(c);
            total++; if (m_q.size() == 0 || inst !== m_q[0].inst || w_inst !== m_q[0].inst) begin
               bad++; $display("FAIL stream_inst: got %h/%h want model head", inst, w_inst);
            end
         end
         total++; if (w_inst_valid !== (m_q.size() != 0) || w_stall_req !== (m_q.size() == 0)) begin
            bad++; $display("FAIL stream_w_valid: got v=%b s=%b want v=%b", w_inst_valid,
                            w_stall_req, m_q.size() != 0);
         end
         cycle();
      end
      total++; if (seen.size() != 4) begin
         bad++; $display("FAIL stream_count: got %0d want 4", seen.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++; if (seen[i] !== exp_pc[i]) begin
               bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, seen[i], exp_pc[i]);
            end
            total++; if (wseen[i] !== exp_wpc[i]) begin
               bad++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, wseen[i], exp_wpc[i]);
            end
            if (i > 0) begin
               total++; if (seen_cyc[i] - seen_cyc[i-1] != 2) begin
                  bad++; $display("FAIL stream_gap[%0d]: got %0d want 2", i, seen_cyc[i] - seen_cyc[i-1]);
               end
            end
         end
      end
   endtask

   task automatic test_fill();
      logic [31:0] addrs[$];
      logic [31:0] pops[$];
      logic [31:0] resume_addr = 32'hDEAD_BEEF;
      logic        prev;
      apply_reset();
      stall = 1'b1;
      prev  = mem_req;
      for (int c = 0; c < 14; c++) begin
         cycle();
         if (mem_req && !prev) addrs.push_back(mem_addr);
         prev = mem_req;
      end
      total++; if (addrs.size() != 4) begin
         bad++; $display("FAIL fill_reqs: got %0d want 4", addrs.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++; if (addrs[i] !== 32'(i * 4)) begin
               bad++; $display("FAIL fill_addr[%0d]: got %h want %h", i, addrs[i], i * 4);
            end
         end
      end
      total++; if (mem_req !== 1'b0 || inst_valid !== 1'b1 || pc !== 32'h0) begin
         bad++; $display("FAIL fill_full: got req=%b v=%b pc=%h want 0 1 0", mem_req, inst_valid, pc);
      end
      stall = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (inst_valid && pops.size() < 4) pops.push_back(pc);
         if (mem_req && !prev && resume_addr === 32'hDEAD_BEEF) resume_addr = mem_addr;
         prev = mem_req;
         cycle();
      end
      for (int i = 0; i < 4; i++) begin
         total++; if (pops.size() <= i || pops[i] !== 32'(i * 4)) begin
            bad++; $display("FAIL fill_pop[%0d]: got %h want %h", i,
                            (pops.size() > i) ? pops[i] : 32'hX, i * 4);
         end
      end
      total++; if (resume_addr !== 32'h10) begin
         bad++; $display("FAIL fill_resume: got %h want 00000010", resume_addr);
      end
   endtask

   task automatic test_redirect_wait();
      int c;
      apply_reset();
      stall = 1'b1;
      for (c = 0; c < 20 && !(mem_req && mem_addr == 32'h8); c++) cycle();
      total++; if (c == 20) begin bad++; $display("FAIL rdw_setup: got timeout want req at 8"); end
      resp_en = 0; use_npc = 1'b1; npc_addr = 32'h103;
      cycle();
      use_npc = 1'b0;
      total++; if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8) begin
         bad++; $display("FAIL rdw_discard: got v=%b req=%b addr=%h want 0 1 8", inst_valid, mem_req, mem_addr);
      end
      cycle();
      cycle();
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
         bad++; $display("FAIL rdw_hold: got req=%b addr=%h want 1 8", mem_req, mem_addr);
      end
      resp_en = 1;
      cycle();
      total++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
         bad++; $display("FAIL rdw_drop: got req=%b v=%b want 0 0", mem_req, inst_valid);
      end
      cycle();
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
         bad++; $display("FAIL rdw_target: got req=%b addr=%h want 1 100", mem_req, mem_addr);
      end
      stall = 1'b0;
      for (c = 0; c < 10 && !inst_valid; c++) cycle();
      total++; if (pc !== 32'h100 || m_q.size() == 0 || inst !== m_q[0].inst) begin
         bad++; $display("FAIL rdw_first: got pc=%h inst=%h want pc=100 and new data", pc, inst);
      end
   endtask

   task automatic test_redirect_ack_pop();
      int c;
      apply_reset();
      stall = 1'b1;
      for (c = 0; c < 20 && !(inst_valid && mem_req); c++) cycle();
      total++; if (c == 20) begin bad++; $display("FAIL rap_setup: got timeout want valid+req"); end
      stall = 1'b0; use_npc = 1'b1; npc_addr = 32'h203;
      cycle();
      use_npc = 1'b0;
      total++; if (!last_ack) begin bad++; $display("FAIL rap_ack: got no ack want ack"); end
      total++; if (inst_valid !== 1'b0 || mem_req !== 1'b0 || pc !== 32'h200) begin
         bad++; $display("FAIL rap_flush: got v=%b req=%b pc=%h want 0 0 200", inst_valid, mem_req, pc);
      end
      cycle();
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
         bad++; $display("FAIL rap_next: got req=%b addr=%h want 1 200", mem_req, mem_addr);
      end
   endtask

   task automatic test_reset_discard();
      apply_reset();
      stall = 1'b1; resp_en = 0;
      cycle();
      use_npc = 1'b1; npc_addr = 32'h300;
      cycle();
      use_npc = 1'b0; rdy = 1'b0;
      cycle();
      cycle();
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || pc !== 32'h300) begin
         bad++; $display("FAIL rd_frozen: got req=%b addr=%h pc=%h want 1 0 300", mem_req, mem_addr, pc);
      end
      #2 rst = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || pc !== 32'h0 || inst !== 32'h0 ||
                   inst_valid !== 1'b0 || stall_req !== 1'b1) begin
         bad++; $display("FAIL rd_async: got req=%b addr=%h pc=%h inst=%h v=%b s=%b want 0 0 0 0 0 1",
                         mem_req, mem_addr, pc, inst, inst_valid, stall_req);
      end
      @(posedge clk);
      #1;
      rst = 1'b1; rdy = 1'b1; resp_en = 1;
      model_reset();
      cycle();
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
         bad++; $display("FAIL rd_restart: got req=%b addr=%h want 1 0", mem_req, mem_addr);
      end
   endtask

   task automatic test_random();
      logic exp_v;
      apply_reset();
      max_delay = 3;
      for (int c = 0; c < 600; c++) begin
         rdy      = ($urandom % 8) != 0;
         stall    = ($urandom % 3) == 0;
         use_npc  = ($urandom % 12) == 0;
         npc_addr = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
         cycle();
         exp_v = (m_q.size() != 0);
         total++; if (mem_req !== m_busy || (m_busy && mem_addr !== m_addr)) begin
            bad++; $display("FAIL rnd_mem c=%0d: got req=%b addr=%h want req=%b addr=%h", c,
                            mem_req, mem_addr, m_busy, m_addr);
         end
         total++; if (inst_valid !== exp_v || stall_req !== !exp_v) begin
            bad++; $display("FAIL rnd_valid c=%0d: got v=%b s=%b want v=%b", c, inst_valid, stall_req, exp_v);
         end
         total++; if (pc !== (exp_v ? m_q[0].pc : m_fetch) || inst !== (exp_v ? m_q[0].inst : 32'h0)) begin
            bad++; $display("FAIL rnd_head c=%0d: got pc=%h inst=%h want pc=%h inst=%h", c, pc, inst,
                            exp_v ? m_q[0].pc : m_fetch, exp_v ? m_q[0].inst : 32'h0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_fill();
      test_redirect_wait();
      test_redirect_ack_pop();
      test_reset_discard();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want test completion");
      $fatal(1);
   end

endmodule
